// File: rtl/dpram_fifo_ctrl.sv
// Synchronous FIFO controller driving both ports of a 16x8 dual-port RAM (A writes, B reads).
// Define FIFO_CTRL_ERR_EN to add sticky overflow/underflow flags.
module dpram_fifo_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   output logic              full,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic              pop_valid,
   output logic              empty,
   output logic [ADDR_W:0]   count,
`ifdef FIFO_CTRL_ERR_EN
   output logic              overflow,
   output logic              underflow,
`endif
   output logic [DATA_W-1:0] ram_in_a,
   output logic [ADDR_W-1:0] ram_address_a,
   output logic              ram_wr_en_a,
   output logic [DATA_W-1:0] ram_in_b,
   output logic [ADDR_W-1:0] ram_address_b,
   output logic              ram_wr_en_b,
   input  logic [DATA_W-1:0] ram_out_b
);

   localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              pop_valid_q;
   logic              push_acc, pop_acc;

   // Flags come from the registered count so both accept paths see the same pre-edge state.
   assign full     = (count_q == DEPTH);
   assign empty    = (count_q == '0);
   assign push_acc = push & ~full & ~rst;
   assign pop_acc  = pop & ~empty & ~rst;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_acc)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_acc && !pop_acc)      count_d = count_q + 1'b1;
      else if (pop_acc && !push_acc) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         pop_valid_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         pop_valid_q <= pop_acc;
      end
   end

`ifdef FIFO_CTRL_ERR_EN
   logic overflow_q, underflow_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (push && full) overflow_q  <= 1'b1;
         if (pop && empty) underflow_q <= 1'b1;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`endif

   // RAM port B reads rd_ptr every edge, so the word for a pop is ready the following cycle.
   assign count         = count_q;
   assign pop_valid     = pop_valid_q;
   assign pop_data      = ram_out_b;
   assign ram_in_a      = push_data;
   assign ram_address_a = wr_ptr_q;
   assign ram_wr_en_a   = push_acc;
   assign ram_in_b      = '0;
   assign ram_address_b = rd_ptr_q;
   assign ram_wr_en_b   = 1'b0;

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl: behavioural RAM plus a queue-based FIFO model checked every cycle.
module tb_dpram_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst, push, pop;
   logic [7:0] push_data, pop_data, ram_in_a, ram_in_b, ram_out_b;
   logic       full, empty, pop_valid, ram_wr_en_a, ram_wr_en_b;
   logic [4:0] count;
   logic [3:0] ram_address_a, ram_address_b;
`ifdef FIFO_CTRL_ERR_EN
   logic       overflow, underflow;
`endif

   dpram_fifo_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
      .clk(clk), .rst(rst), .push(push), .push_data(push_data), .full(full),
      .pop(pop), .pop_data(pop_data), .pop_valid(pop_valid), .empty(empty), .count(count),
`ifdef FIFO_CTRL_ERR_EN
      .overflow(overflow), .underflow(underflow),
`endif
      .ram_in_a(ram_in_a), .ram_address_a(ram_address_a), .ram_wr_en_a(ram_wr_en_a),
      .ram_in_b(ram_in_b), .ram_address_b(ram_address_b), .ram_wr_en_b(ram_wr_en_b),
      .ram_out_b(ram_out_b)
   );

   always #5 clk = ~clk;

   // 16x8 RAM with registered port-B output
   logic [7:0] mem [16];
   always @(posedge clk) begin
      if (ram_wr_en_a) mem[ram_address_a] <= ram_in_a;
      if (ram_wr_en_b) mem[ram_address_b] <= ram_in_b;
      ram_out_b <= mem[ram_address_b];
   end

   int checks = 0;
   int failures = 0;

   logic [7:0] q[$];
   int         n_push = 0, n_pop = 0;
   logic       exp_pv = 1'b0;
   logic [7:0] exp_pd = '0;
   logic       exp_ovf = 1'b0, exp_unf = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, check combinational RAM drive, advance model, check registered outputs.
   task automatic cyc(input logic r, input logic pu, input logic [7:0] d, input logic po);
      bit acc_push, acc_pop;
      rst = r; push = pu; push_data = d; pop = po;
      #1;
      acc_push = pu && !r && (q.size() < 16);
      acc_pop  = po && !r && (q.size() > 0);
      chk("ram_wr_en_a", 32'(ram_wr_en_a), 32'(acc_push));
      chk("ram_wr_en_b", 32'(ram_wr_en_b), 0);
      chk("ram_in_b", 32'(ram_in_b), 0);
      if (!r) begin
         chk("ram_in_a", 32'(ram_in_a), 32'(d));
         chk("ram_address_a", 32'(ram_address_a), 32'(n_push % 16));
         chk("ram_address_b", 32'(ram_address_b), 32'(n_pop % 16));
      end
      if (r) begin
         q.delete(); n_push = 0; n_pop = 0; exp_pv = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
      end else begin
         if (pu && q.size() == 16) exp_ovf = 1'b1;
         if (po && q.size() == 0)  exp_unf = 1'b1;
         exp_pv = acc_pop;
         if (acc_pop) begin exp_pd = q.pop_front(); n_pop++; end
         if (acc_push) begin q.push_back(d); n_push++; end
      end
      @(posedge clk);
      @(negedge clk);
      chk("count", 32'(count), 32'(q.size()));
      chk("full", 32'(full), 32'(q.size() == 16));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("pop_valid", 32'(pop_valid), 32'(exp_pv));
      if (exp_pv) chk("pop_data", 32'(pop_data), 32'(exp_pd));
`ifdef FIFO_CTRL_ERR_EN
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      chk("underflow", 32'(underflow), 32'(exp_unf));
`endif
   endtask

   initial begin
      rst = 1'b1; push = 1'b0; pop = 1'b0; push_data = '0;
      @(negedge clk);
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      chk("reset_count_lit", 32'(count), 0);
      chk("reset_empty_lit", 32'(empty), 1);
      chk("reset_valid_lit", 32'(pop_valid), 0);

      // Fill with 0x10..0x1F
      for (int i = 0; i < 16; i++) cyc(0, 1, 8'(8'h10 + i), 0);
      chk("fill_count_lit", 32'(count), 16);
      chk("fill_full_lit", 32'(full), 1);

      // Overflow attempt
      cyc(0, 1, 8'hAA, 0);
      chk("ovf_count_lit", 32'(count), 16);
      cyc(0, 0, 0, 0);

      // Drain back-to-back
      for (int i = 0; i < 16; i++) begin
         cyc(0, 0, 0, 1);
         chk("drain_data_lit", 32'(pop_data), 32'(8'h10 + i));
         chk("drain_valid_lit", 32'(pop_valid), 1);
      end
      chk("drain_empty_lit", 32'(empty), 1);
      cyc(0, 0, 0, 0);
      chk("drain_after_valid_lit", 32'(pop_valid), 0);

      // Underflow attempt
      cyc(0, 0, 0, 1);
      chk("unf_valid_lit", 32'(pop_valid), 0);

      // Pointer wrap: push 8, pop 8, push 12, pop 12
      for (int i = 0; i < 8; i++) cyc(0, 1, 8'(8'h30 + i), 0);
      for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1);
      for (int i = 0; i < 12; i++) cyc(0, 1, 8'(8'h40 + i), 0);
      chk("wrap_addr_a_lit", 32'(ram_address_a), 4);
      for (int i = 0; i < 12; i++) begin
         cyc(0, 0, 0, 1);
         chk("wrap_data_lit", 32'(pop_data), 32'(8'h40 + i));
      end
      cyc(0, 0, 0, 0);

      // Simultaneous push/pop with count=3
      cyc(0, 1, 8'h01, 0);
      cyc(0, 1, 8'h02, 0);
      cyc(0, 1, 8'h03, 0);
      cyc(0, 1, 8'h55, 1);
      chk("simul_count_lit", 32'(count), 3);
      chk("simul_data_lit", 32'(pop_data), 32'h01);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
      chk("simul_last_lit", 32'(pop_data), 32'h55);
      cyc(0, 0, 0, 0);

      // Simultaneous push/pop on empty
      cyc(0, 1, 8'h66, 1);
      chk("empty_simul_count_lit", 32'(count), 1);
      chk("empty_simul_valid_lit", 32'(pop_valid), 0);
      cyc(0, 0, 0, 1);
      chk("empty_simul_data_lit", 32'(pop_data), 32'h66);
      cyc(0, 0, 0, 0);

      // Reset with count=5 and a pop in flight
      for (int i = 0; i < 6; i++) cyc(0, 1, 8'(8'h70 + i), 0);
      cyc(0, 0, 0, 1);
      chk("pre_rst_count_lit", 32'(count), 5);
      cyc(1, 0, 0, 0);
      chk("rst_count_lit", 32'(count), 0);
      chk("rst_empty_lit", 32'(empty), 1);
      chk("rst_valid_lit", 32'(pop_valid), 0);
      cyc(0, 0, 0, 1);
      chk("post_rst_valid_lit", 32'(pop_valid), 0);

      // Mixed random-ish traffic against the model
      for (int i = 0; i < 200; i++)
         cyc(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
